button_debounce_array: RTL

BUTTON_DEBOUNCE_ARRAY -- requirements
Module: button_debounce_array

---
 rtl/button_debounce_array_pkg.sv | 22 ++
 rtl/button_debounce_array_btn_chan.sv | 133 +++++++++++++
 rtl/button_debounce_array.sv | 43 ++++
 3 files changed

// File: rtl/button_debounce_array_pkg.sv
// Shared types and default timing for the button debounce array.
// Holds the per-channel FSM state encoding and a counter-width helper.
package button_debounce_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } btn_state_t;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_DEB_CYC    = 20000;
    localparam int DEF_LONG_CYC   = 1000000;
    localparam int DEF_RPT_CYC    = 200000;
    localparam int DEF_ACTIVE_LOW = 1;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debounce_array_btn_chan.sv
// One button channel: synchroniser, debounce filter and
// press / long-press / auto-repeat event generator.
module btn_chan
    import button_debounce_array_pkg::*;
#(
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int LONG_CYC   = DEF_LONG_CYC,
    parameter int RPT_CYC    = DEF_RPT_CYC,
    parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_rpt
);

    localparam logic IDLE_RAW = (ACTIVE_LOW != 0);
    localparam int   DW       = cnt_w(DEB_CYC);
    localparam int   LW       = cnt_w(LONG_CYC);
    localparam int   RW       = cnt_w(RPT_CYC);
    localparam int   HW       = (LW > RW) ? LW : RW;

    localparam logic [DW-1:0] DEB_T  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] LONG_T = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] RPT_T  =
        HW'((RPT_CYC == 0) ? 0 : RPT_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_deb;
    logic [HW-1:0] r_hold;
    btn_state_t    r_state;

    logic w_sample;
    logic w_diff;
    logic w_done;
    logic w_rise;
    logic w_fall;

    // pressed = 1 regardless of pin polarity
    assign w_sample = r_sync2 ^ IDLE_RAW;
    assign w_diff   = (w_sample != o_level);
    assign w_done   = w_diff && (r_deb == DEB_T);
    assign w_rise   = w_done && !o_level;
    assign w_fall   = w_done && o_level;

    // Two-flop synchroniser, reset to the not-pressed pin level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= IDLE_RAW;
            r_sync2 <= IDLE_RAW;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: count stable disagreement, flip level when it lasts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb     <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_press   <= w_rise;
            o_release <= w_fall;
            if (w_done) begin
                o_level <= !o_level;
            end
            if (!w_diff || w_done) begin
                r_deb <= '0;
            end else begin
                r_deb <= r_deb + DW'(1);
            end
        end
    end

    // Hold FSM; a release always wins over a long/repeat event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            o_long  <= 1'b0;
            o_rpt   <= 1'b0;
        end else begin
            o_long <= 1'b0;
            o_rpt  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_hold <= '0;
                    if (w_rise) begin
                        r_state <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                        r_hold  <= '0;
                    end else if (r_hold == LONG_T) begin
                        r_state <= ST_LONG;
                        r_hold  <= '0;
                        o_long  <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                ST_LONG: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                        r_hold  <= '0;
                    end else if (RPT_CYC == 0) begin
                        r_hold <= '0;
                    end else if (r_hold == RPT_T) begin
                        r_hold <= '0;
                        o_rpt  <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_debounce_array.sv
// Array of independent debounced button channels.
// any_event is the only logic shared between channels.
module button_debounce_array
    import button_debounce_array_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int LONG_CYC   = DEF_LONG_CYC,
    parameter int RPT_CYC    = DEF_RPT_CYC,
    parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long,
    output logic [N_CH-1:0] btn_rpt,
    output logic            any_event
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_chan #(
            .DEB_CYC   (DEB_CYC),
            .LONG_CYC  (LONG_CYC),
            .RPT_CYC   (RPT_CYC),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_btn    (btn_in[i]),
            .o_level  (btn_level[i]),
            .o_press  (btn_press[i]),
            .o_release(btn_release[i]),
            .o_long   (btn_long[i]),
            .o_rpt    (btn_rpt[i])
        );
    end

    assign any_event = |(btn_press | btn_release | btn_long | btn_rpt);

endmodule
